// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: stages operands for the external combinational ALU and
// captures its result. Operand A is taken from bus_in in the start cycle and
// operand B in the cycle after that. The opcode and both operands then stay
// stable while the ALU works. Multiply and divide get extra cycles. The ALU
// result is captured into zhi_q/zlo_q, and done pulses for one cycle.
module alu_op_sequencer #(
   parameter int DATA_W        = 32,
   parameter int SHAMT_W       = 5,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic [4:0]            opcode,
   input  logic [DATA_W-1:0]     bus_in,
   input  logic [2*DATA_W-1:0]   alu_z,
   output logic [4:0]            op_q,
   output logic [DATA_W-1:0]     y_q,
   output logic [DATA_W-1:0]     b_q,
   output logic [DATA_W-1:0]     zhi_q,
   output logic [DATA_W-1:0]     zlo_q,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [4:0] OP_SHR = 5'd4;
   localparam logic [4:0] OP_ROL = 5'd8;
   localparam logic [4:0] OP_MUL = 5'd9;
   localparam logic [4:0] OP_DIV = 5'd10;
   localparam logic [4:0] OP_NOT = 5'd12;

   localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_B,
      S_EXEC,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;

   logic               is_shift;
   logic               is_legal;
   logic               is_muldiv;
   logic               div_zero;
   logic [DATA_W-1:0]  b_load;
   logic [DATA_W-1:0]  cap_zhi;
   logic [DATA_W-1:0]  cap_zlo;
   logic               cap_err;

   // The opcode is already latched when B is loaded, so decode from op_q.
   assign is_shift  = (op_q >= OP_SHR) && (op_q <= OP_ROL);
   assign is_legal  = (op_q <= OP_NOT);
   assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
   assign div_zero  = (op_q == OP_DIV) && (b_q == '0);

   // For shifts and rotates only the count bits are kept, so a count of 33 means 1.
   assign b_load = is_shift ? DATA_W'(bus_in[SHAMT_W-1:0]) : bus_in;

   // Status outputs are decoded from the state register only.
   assign busy = (state == S_LOAD_B) || (state == S_EXEC) || (state == S_WAIT);
   assign done = (state == S_DONE);

   // Select what is written into Z and err for the current opcode.
   always_comb begin
      // NOTE: every output gets a default first, so no path can leave a value unassigned and infer a latch.
      cap_zhi = '0;
      cap_zlo = alu_z[DATA_W-1:0];
      cap_err = 1'b0;
      if (op_q == OP_MUL || (op_q == OP_DIV && !div_zero)) begin
         cap_zhi = alu_z[2*DATA_W-1:DATA_W];
      end
      if (div_zero) begin
         cap_zlo = '0;
         cap_err = 1'b1;
      end
   end

   // Sequencer FSM: operand staging, mul/div wait count, and result capture.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= '0;
         y_q   <= '0;
         b_q   <= '0;
         zhi_q <= '0;
         zlo_q <= '0;
         err   <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch reads the pre-edge values.
         case (state)
            S_IDLE, S_DONE: begin
               err <= 1'b0;
               if (start) begin
                  y_q   <= bus_in;
                  op_q  <= opcode;
                  state <= S_LOAD_B;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_LOAD_B: begin
               b_q   <= b_load;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (!is_legal) begin
                  err   <= 1'b1;
                  state <= S_DONE;
               end else if (is_muldiv && (MULDIV_CYCLES > 1)) begin
                  cnt   <= CNT_W'(MULDIV_CYCLES - 1);
                  state <= S_WAIT;
               end else begin
                  zhi_q <= cap_zhi;
                  zlo_q <= cap_zlo;
                  err   <= cap_err;
                  state <= S_DONE;
               end
            end
            S_WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  zhi_q <= cap_zhi;
                  zlo_q <= cap_zlo;
                  err   <= cap_err;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer. A reference ALU
// computes alu_z from op_q/y_q/b_q. Expected results are queued when an
// operation is issued, then compared when done is observed.
module tb_alu_op_sequencer;

   localparam int MC = 4;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [4:0]  opcode;
   logic [31:0] bus_in;
   logic [63:0] alu_z;
   logic [4:0]  op_q;
   logic [31:0] y_q, b_q, zhi_q, zlo_q;
   logic        busy, done, err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] zhi;
      logic [31:0] zlo;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   logic [31:0] model_zhi = '0;
   logic [31:0] model_zlo = '0;

   alu_op_sequencer #(.DATA_W(32), .SHAMT_W(5), .MULDIV_CYCLES(MC)) dut (
      .clk    (clk),
      .clr    (clr),
      .start  (start),
      .opcode (opcode),
      .bus_in (bus_in),
      .alu_z  (alu_z),
      .op_q   (op_q),
      .y_q    (y_q),
      .b_q    (b_q),
      .zhi_q  (zhi_q),
      .zlo_q  (zlo_q),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Reference ALU. Single-word ops put junk in the upper half to show that it is ignored.
   function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
      logic [63:0] t;
      case (op)
         5'd0:  return {~y, y + b};
         5'd1:  return {~y, y - b};
         5'd2:  return {~y, y & b};
         5'd3:  return {~y, y | b};
         5'd4:  return {~y, y >> b};
         5'd5:  return {~y, 32'($signed(y) >>> b)};
         5'd6:  return {~y, y << b};
         5'd7:  begin t = {y, y} >> b; return {~y, t[31:0]}; end
         5'd8:  begin t = {y, y} << b; return {~y, t[63:32]}; end
         5'd9:  return 64'($signed({{32{y[31]}}, y}) * $signed({{32{b[31]}}, b}));
         5'd10: begin
            if (b == 0) return 64'h0BAD_0BAD_0BAD_0BAD;
            return {32'($signed(y) % $signed(b)), 32'($signed(y) / $signed(b))};
         end
         5'd11: return {~y, -y};
         5'd12: return {~y, ~y};
         default: return 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
   endfunction

   always_comb alu_z = alu_ref(op_q, y_q, b_q);

   // Drive the start cycle and the B cycle, queue the expected outcome, and return in LOAD_B.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] r;
      e.op  = op;
      e.a   = a;
      e.b   = (op >= 5'd4 && op <= 5'd8) ? {27'd0, b[4:0]} : b;
      r     = alu_ref(op, a, e.b);
      e.err = 1'b0;
      e.lat = (op == 5'd9 || op == 5'd10) ? 1 + MC : 2;
      if (op > 5'd12) begin
         e.err = 1'b1;
      end else if (op == 5'd9 || (op == 5'd10 && e.b != 0)) begin
         model_zhi = r[63:32];
         model_zlo = r[31:0];
      end else if (op == 5'd10) begin
         model_zhi = '0;
         model_zlo = '0;
         e.err     = 1'b1;
      end else begin
         model_zhi = '0;
         model_zlo = r[31:0];
      end
      e.zhi = model_zhi;
      e.zlo = model_zlo;
      sb.push_back(e);
      opcode = op;
      bus_in = a;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bus_in = b;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL load_b_status: busy=%b done=%b err=%b, required 1 0 0", busy, done, err);
      end
      checks++;
      if (y_q !== a || op_q !== op) begin
         failures++;
         $display("FAIL load_a: y_q=%h op_q=%0d, required %h %0d", y_q, op_q, a, op);
      end
   endtask

   // Wait for done, with a bound, and compare it against the queued expectation. poke drives start and bus_in while busy.
   task automatic wait_done(input bit poke, output int nbusy);
      exp_t e;
      int   lat;
      bit   seen;
      e     = sb.pop_front();
      lat   = 0;
      nbusy = 1;
      seen  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (poke) begin
            start  = 1'b1;
            opcode = 5'($urandom);
            if (i > 0) bus_in = $urandom;
         end
         @(negedge clk);
         lat++;
         if (done === 1'b1) seen = 1;
         else if (busy === 1'b1) nbusy++;
      end
      start = 1'b0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL done_timeout: op=%0d no done within 20 cycles", e.op);
         return;
      end
      checks++;
      if (lat !== e.lat || busy !== 1'b0) begin
         failures++;
         $display("FAIL latency: op=%0d cycles=%0d busy=%b, required %0d 0", e.op, lat, busy, e.lat);
      end
      checks++;
      if (zhi_q !== e.zhi || zlo_q !== e.zlo || err !== e.err) begin
         failures++;
         $display("FAIL result: op=%0d zhi=%h zlo=%h err=%b, required %h %h %b",
                  e.op, zhi_q, zlo_q, err, e.zhi, e.zlo, e.err);
      end
      checks++;
      if (op_q !== e.op || y_q !== e.a || b_q !== e.b) begin
         failures++;
         $display("FAIL operands_held: op=%0d y=%h b=%h, required %0d %h %h", op_q, y_q, b_q, e.op, e.a, e.b);
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({op_q, y_q, b_q, zhi_q, zlo_q, busy, done, err} !== '0) begin
         failures++;
         $display("FAIL %s: op=%0d y=%h b=%h zhi=%h zlo=%h busy=%b done=%b err=%b, required all 0",
                  name, op_q, y_q, b_q, zhi_q, zlo_q, busy, done, err);
      end
   endtask

   task automatic test_reset();
      int nb;
      clr = 1'b1; start = 1'b0; opcode = '0; bus_in = '0;
      repeat (2) @(negedge clk);
      check_zero("reset_initial");
      clr = 1'b0;
      @(negedge clk);
      issue(5'd0, 32'd3, 32'd4);
      wait_done(0, nb);
      @(negedge clk);
      // A mul is aborted in WAIT by clr.
      opcode = 5'd9; bus_in = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0; bus_in = 32'd6;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      #1;
      check_zero("reset_async");
      @(negedge clk);
      check_zero("reset_next_cycle");
      clr = 1'b0;
      model_zhi = '0;
      model_zlo = '0;
      @(negedge clk);
      check_zero("reset_idle_after");
      issue(5'd0, 32'd5, 32'd6);
      wait_done(0, nb);
      @(negedge clk);
   endtask

   task automatic test_rol();
      int nb;
      issue(5'd8, 32'h8000_0001, 32'd4);
      wait_done(0, nb);
      checks++;
      if (zlo_q !== 32'h0000_0018 || zhi_q !== 32'h0 || b_q !== 32'd4) begin
         failures++;
         $display("FAIL rol: zlo=%h zhi=%h b=%h, required 00000018 0 4", zlo_q, zhi_q, b_q);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse: done=%b busy=%b, required 0 0", done, busy);
      end
      issue(5'd8, 32'h8000_0001, 32'h0000_0021);
      wait_done(0, nb);
      checks++;
      if (b_q !== 32'd1 || zlo_q !== 32'h0000_0003) begin
         failures++;
         $display("FAIL count_mask: b=%h zlo=%h, required 1 3", b_q, zlo_q);
      end
      @(negedge clk);
   endtask

   task automatic test_mul();
      int nb;
      issue(5'd9, 32'hFFFF_FFFF, 32'd2);
      wait_done(1, nb);
      checks++;
      if (nb !== 5 || zhi_q !== 32'hFFFF_FFFF || zlo_q !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL mul: busy_cycles=%0d zhi=%h zlo=%h, required 5 ffffffff fffffffe", nb, zhi_q, zlo_q);
      end
      @(negedge clk);
   endtask

   task automatic test_div();
      int nb;
      issue(5'd10, 32'd7, 32'd0);
      wait_done(0, nb);
      checks++;
      if (zhi_q !== 32'd0 || zlo_q !== 32'd0 || err !== 1'b1 || done !== 1'b1) begin
         failures++;
         $display("FAIL div_zero: zhi=%h zlo=%h err=%b done=%b, required 0 0 1 1", zhi_q, zlo_q, err, done);
      end
      issue(5'd10, 32'd7, 32'd2);
      wait_done(0, nb);
      checks++;
      if (zhi_q !== 32'd1 || zlo_q !== 32'd3 || err !== 1'b0) begin
         failures++;
         $display("FAIL div: zhi=%h zlo=%h err=%b, required 1 3 0", zhi_q, zlo_q, err);
      end
   endtask

   // Runs directly after test_div, so the illegal op must keep the Z values from the divide.
   task automatic test_back_to_back();
      int nb;
      issue(5'd20, 32'h1234_5678, 32'h9);
      wait_done(0, nb);
      checks++;
      if (err !== 1'b1 || zhi_q !== 32'd1 || zlo_q !== 32'd3) begin
         failures++;
         $display("FAIL illegal: err=%b zhi=%h zlo=%h, required 1 1 3", err, zhi_q, zlo_q);
      end
      issue(5'd1, 32'd10, 32'd3);
      wait_done(0, nb);
      checks++;
      if (zlo_q !== 32'd7 || zhi_q !== 32'd0 || err !== 1'b0) begin
         failures++;
         $display("FAIL b2b_sub: zlo=%h zhi=%h err=%b, required 7 0 0", zlo_q, zhi_q, err);
      end
      for (int i = 0; i < 13; i++) begin
         issue(5'(i), $urandom, (i == 10) ? 32'($urandom_range(1, 1000)) : $urandom);
         wait_done(0, nb);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rol();
      test_mul();
      test_div();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
